imem_boot_loader: RTL
=====================

// Module: imem_boot_loader
// PURPOSE
//  Upstream feeder for theProcessor. Receives a program as a byte stream (valid/ready),
//  packs bytes into 32-bit instruction words, and writes them into the instruction memory
//  write port. Holds the processor in reset (cpu_rst) until the whole image is loaded,
//  then releases it so execution starts at BASE_ADDR.
// PARAMETERS
//  IMEM_DEPTH  256  instruction memory capacity in 32-bit words; max accepted word count
//  BASE_ADDR   0    byte address of the first loaded word; word k goes to BASE_ADDR+4*k
// PORTS
//  clk          in   1   system clock; all logic on rising edge
//  rst          in   1   synchronous, active-high reset
//  rx_data      in   8   incoming byte
//  rx_valid     in   1   rx_data valid
//  rx_ready     out  1   loader accepts a byte; transfer = rx_valid & rx_ready
//  imem_we      out  1   one-cycle instruction-memory write strobe
//  imem_addr    out  32  byte address of the write
//  imem_wdata   out  32  instruction word
//  cpu_rst      out  1   reset to theProcessor; 1 until load completes
//  load_done    out  1   image loaded, processor released
//  load_err     out  1   image rejected; processor held in reset
//  words_loaded out  16  count of words written so far
// BEHAVIOUR
//  - All outputs registered. Reset values: rx_ready=0, imem_we=0, imem_addr=BASE_ADDR,
//    imem_wdata=0, cpu_rst=1, load_done=0, load_err=0, words_loaded=0; state=HDR0.
//  - States: HDR0, HDR1, LOAD, WRITE, [CHK], DONE, ERR.
//  - rx_ready=1 in HDR0/HDR1/LOAD/CHK; 0 in WRITE/DONE/ERR. Stalls (rx_valid=0) hold state.
//  - HDR0: accepted byte -> N[15:8]. HDR1: accepted byte -> N[7:0]; next state:
//    N==0 -> DONE (or CHK w/ checksum); N>IMEM_DEPTH -> ERR; else LOAD.
//  - LOAD: bytes big-endian (first byte -> bits 31:24). 2-bit byte counter; on 4th accepted
//    byte go to WRITE.
//  - WRITE (exactly 1 cycle): imem_we=1, imem_addr=BASE_ADDR+4*words_loaded,
//    imem_wdata=packed word; words_loaded increments at end of the cycle. Then
//    words_loaded==N -> DONE (or CHK); else LOAD.
//  - Address arithmetic 32-bit, no wrap possible since N<=IMEM_DEPTH.
//  - DONE: cpu_rst=0, load_done=1, same cycle; terminal until rst.
//  - ERR: load_err=1, cpu_rst=1, no further writes; terminal until rst.
//  - Bytes arriving in DONE/ERR are not accepted (rx_ready=0).
//  - rst mid-load: next cycle all outputs at reset values, partial word discarded,
//    new header expected; already-written imem contents are not cleared.
//  - Latency: last payload byte accepted at cycle t -> imem_we at t+1 -> load_done at t+2.
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined: after the last word (or after header when N==0)
//   enter CHK; accept one byte = XOR of all payload bytes (header excluded; N==0 -> 0x00).
//   Match -> DONE; mismatch -> ERR.
//  Not defined: CHK state absent; transitions go directly to DONE.
// TESTING
//  1. rst 2 cycles; stream 00 01 20 08 00 05 -> one imem_we, addr 0x0, data 0x20080005;
//     load_done=1, cpu_rst=0 two cycles after last byte; words_loaded=1.
//  2. Stream 00 00 -> no imem_we; load_done=1 one cycle after second byte.
//  3. N=3 with random rx_valid gaps -> writes at 0x0, 0x4, 0x8 in order, data intact;
//     rx_ready=0 during each WRITE cycle.
//  4. IMEM_DEPTH=256, header 01 01 -> load_err=1, cpu_rst stays 1, rx_ready=0, no writes.
//  5. rst asserted after 5 bytes of an N=2 image -> outputs return to reset values;
//     fresh image 00 01 AA BB CC DD loads 0xAABBCCDD at 0x0.
//  6. IMEM_LOADER_CHECKSUM_EN: 00 01 11 22 33 44 44 -> load_done=1;
//     same with final byte 45 -> load_err=1, cpu_rst=1.

Source files
------------

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - packs a byte-stream program image into imem words and releases cpu_rst when loaded
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module imem_boot_loader #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {HDR0, HDR1, LOAD, WRITE, CHK, DONE, ERR} state_t;
  localparam state_t FINISH = CHK;
`else
  typedef enum logic [2:0] {HDR0, HDR1, LOAD, WRITE, DONE, ERR} state_t;
  localparam state_t FINISH = DONE;
`endif

  localparam logic [16:0] DEPTH_LIMIT = 17'(IMEM_DEPTH);

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic        ready_next;
  logic [15:0] n_full;
  logic [15:0] n_words;
  logic [23:0] word_buf;
  logic [1:0]  byte_cnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  always_comb begin
    state_next = state;
    accept     = rx_valid && rx_ready;
    n_full     = {n_words[15:8], rx_data};
    case (state)
      HDR0: if (accept) state_next = HDR1;
      HDR1: begin
        if (accept) begin
          if (n_full == 16'd0)
            state_next = FINISH;
          else if ({1'b0, n_full} > DEPTH_LIMIT)
            state_next = ERR;
          else
            state_next = LOAD;
        end
      end
      LOAD: if (accept && byte_cnt == 2'd3) state_next = WRITE;
      // words_loaded still holds the pre-increment count during WRITE
      WRITE: state_next = (words_loaded + 16'd1 == n_words) ? FINISH : LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: if (accept) state_next = (rx_data == csum) ? DONE : ERR;
`endif
      DONE: state_next = DONE;
      ERR:  state_next = ERR;
      default: state_next = ERR;
    endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
    ready_next = state_next inside {HDR0, HDR1, LOAD, CHK};
`else
    ready_next = state_next inside {HDR0, HDR1, LOAD};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HDR0;
      rx_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_wdata   <= 32'd0;
      cpu_rst      <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= 16'd0;
      n_words      <= 16'd0;
      word_buf     <= 24'd0;
      byte_cnt     <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= 8'd0;
`endif
    end else begin
      state     <= state_next;
      rx_ready  <= ready_next;
      imem_we   <= (state_next == WRITE);
      cpu_rst   <= (state_next != DONE);
      load_done <= (state_next == DONE);
      load_err  <= (state_next == ERR);

      if (accept) begin
        case (state)
          HDR0: n_words[15:8] <= rx_data;
          HDR1: n_words[7:0]  <= rx_data;
          LOAD: begin
            word_buf <= {word_buf[15:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ rx_data;
`endif
          end
          default: ;
        endcase
      end

      // WRITE is only ever entered from LOAD on the fourth byte of a word
      if (state_next == WRITE) begin
        imem_addr  <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
        imem_wdata <= {word_buf, rx_data};
      end

      if (state == WRITE)
        words_loaded <= words_loaded + 16'd1;
    end
  end

endmodule
